// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with synchronous clamped load, count enable,
// combinational terminal count and a sticky one-shot completion flag.
`timescale 1ns/1ps
module counter_mod_n #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 10,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] Din,
    input  logic             OneShot,
    output logic [WIDTH-1:0] Count,
    output logic             Tc,
    output logic             Done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        term     = Up ? LAST : '0;
        // An out-of-range value steps as if it were the last legal state.
        cur      = (count_q > LAST) ? LAST : count_q;
        load_val = (Din > LAST) ? LAST : Din;
        if (Up) begin
            step = (cur == LAST) ? '0 : cur + WIDTH'(1);
        end else begin
            step = (cur == '0) ? LAST : cur - WIDTH'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        done_d  = done_q;
        if (Load) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (!OneShot) begin
            // Leaving one-shot mode clears Done and resumes counting on the same edge.
            done_d = 1'b0;
            if (En) begin
                count_d = step;
            end
        end else if (En && !done_q) begin
            if (cur == term) begin
                done_d = 1'b1;
            end else begin
                count_d = step;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= RST;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign Count = count_q;
    assign Done  = done_q;
    assign Tc    = En & ~done_q & (count_q == term);

endmodule

// File: tb/tb_counter_mod_n.sv
// Scoreboard bench for counter_mod_n: decimal, RESET_VAL=4, MODULUS=16 and
// two-stage cascade builds.
`timescale 1ns/1ps
module tb_counter_mod_n;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // main decimal DUT (and the RESET_VAL = 4 build sharing its inputs)
    logic       reset = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0, oneshot = 1'b0;
    logic [3:0] din = '0;
    logic [3:0] count, rv4_count;
    logic       tc, done, rv4_tc, rv4_done;

    // MODULUS = 16 build
    logic       m_reset = 1'b0, m_en = 1'b0, m_up = 1'b0, m_load = 1'b0;
    logic [3:0] m_din = '0;
    logic [3:0] m_count;
    logic       m_tc, m_done;

    // cascade
    logic       c_reset = 1'b0, c_en = 1'b0;
    logic [3:0] lo_count, hi_count;
    logic       lo_tc, hi_tc, lo_done, hi_done;

    counter_mod_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut (
        .Clk(clk), .Reset(reset), .En(en), .Up(up), .Load(load), .Din(din),
        .OneShot(oneshot), .Count(count), .Tc(tc), .Done(done));

    counter_mod_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(4)) u_rv4 (
        .Clk(clk), .Reset(reset), .En(en), .Up(up), .Load(load), .Din(din),
        .OneShot(oneshot), .Count(rv4_count), .Tc(rv4_tc), .Done(rv4_done));

    counter_mod_n #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_m16 (
        .Clk(clk), .Reset(m_reset), .En(m_en), .Up(m_up), .Load(m_load), .Din(m_din),
        .OneShot(1'b0), .Count(m_count), .Tc(m_tc), .Done(m_done));

    counter_mod_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_lo (
        .Clk(clk), .Reset(c_reset), .En(c_en), .Up(1'b1), .Load(1'b0), .Din(4'd0),
        .OneShot(1'b0), .Count(lo_count), .Tc(lo_tc), .Done(lo_done));

    counter_mod_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_hi (
        .Clk(clk), .Reset(c_reset), .En(lo_tc), .Up(1'b1), .Load(1'b0), .Din(4'd0),
        .OneShot(1'b0), .Count(hi_count), .Tc(hi_tc), .Done(hi_done));

    typedef struct {
        logic       r, l;
        logic [3:0] d;
        logic       e, u, o;
    } stim_t;

    typedef struct {
        bit         tcv;
        logic       tc;
        logic [3:0] cnt;
        logic       dn;
    } exp_t;

    exp_t sb[$];
    int   cq[$];
    int   m_cnt = 0;
    logic m_dn  = 1'b0;
    bit   m_valid = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    function automatic stim_t mk(logic r, logic l, logic [3:0] d, logic e, logic u, logic o);
        stim_t s;
        s.r = r; s.l = l; s.d = d; s.e = e; s.u = u; s.o = o;
        return s;
    endfunction

    // Drive one cycle of stimulus on the falling edge and push the expected
    // pre-edge Tc and post-edge Count/Done from an integer reference model.
    task automatic apply(input stim_t s);
        exp_t x;
        int   term;
        @(negedge clk);
        reset = s.r; load = s.l; din = s.d; en = s.e; up = s.u; oneshot = s.o;
        term  = s.u ? 9 : 0;
        x.tcv = m_valid;
        x.tc  = m_valid && s.e && !m_dn && (m_cnt == term);
        if (s.r) begin
            m_cnt = 0; m_dn = 1'b0;
        end else if (s.l) begin
            m_cnt = (int'(s.d) > 9) ? 9 : int'(s.d); m_dn = 1'b0;
        end else if (!s.o) begin
            m_dn = 1'b0;
            if (s.e) m_cnt = s.u ? (m_cnt + 1) % 10 : (m_cnt + 9) % 10;
        end else if (s.e && !m_dn) begin
            if (m_cnt == term) m_dn = 1'b1;
            else m_cnt = s.u ? m_cnt + 1 : m_cnt - 1;
        end
        m_valid = 1'b1;
        x.cnt = 4'(m_cnt);
        x.dn  = m_dn;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  x;
        s.push_back(mk(1, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            #1; x = sb[0];
            if (x.tcv) begin
                compared++;
                if (tc !== x.tc) begin mismatched++; $display("FAIL reset_tc[%0d]: got %b want %b", i, tc, x.tc); end
            end
            @(posedge clk); #1; x = sb.pop_front();
            compared++;
            if (count !== x.cnt || done !== x.dn) begin
                mismatched++; $display("FAIL reset_state[%0d]: count=%0d done=%b want count=%0d done=%b", i, count, done, x.cnt, x.dn);
            end
        end
        compared++;
        if (rv4_count !== 4'd4 || rv4_done !== 1'b0) begin
            mismatched++; $display("FAIL reset_val4: count=%0d done=%b want count=4 done=0", rv4_count, rv4_done);
        end
    endtask

    task automatic test_wrap_up();
        exp_t x;
        for (int i = 0; i < 12; i++) begin
            apply(mk(0, 0, 0, 1, 1, 0));
            #1; x = sb[0]; compared++;
            if (tc !== x.tc) begin mismatched++; $display("FAIL wrap_up_tc[%0d]: got %b want %b (count=%0d)", i, tc, x.tc, count); end
            @(posedge clk); #1; x = sb.pop_front(); compared++;
            if (count !== x.cnt || done !== x.dn) begin
                mismatched++; $display("FAIL wrap_up[%0d]: count=%0d done=%b want count=%0d done=%b", i, count, done, x.cnt, x.dn);
            end
        end
    endtask

    task automatic test_down_clamp();
        stim_t s[$];
        exp_t  x;
        s.push_back(mk(0, 1, 3, 1, 0, 0));
        for (int i = 0; i < 5; i++) s.push_back(mk(0, 0, 0, 1, 0, 0));
        s.push_back(mk(0, 1, 14, 1, 1, 0));
        s.push_back(mk(0, 1, 15, 0, 1, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 1, 0));
        foreach (s[i]) begin
            apply(s[i]);
            #1; x = sb[0]; compared++;
            if (tc !== x.tc) begin mismatched++; $display("FAIL down_tc[%0d]: got %b want %b (count=%0d)", i, tc, x.tc, count); end
            @(posedge clk); #1; x = sb.pop_front(); compared++;
            if (count !== x.cnt || done !== x.dn) begin
                mismatched++; $display("FAIL down[%0d]: count=%0d done=%b want count=%0d done=%b", i, count, done, x.cnt, x.dn);
            end
            if (i == 6) begin
                compared++;
                if (count !== 4'd9) begin mismatched++; $display("FAIL load_clamp: count=%0d want 9", count); end
            end
        end
    endtask

    task automatic test_oneshot();
        stim_t s[$];
        exp_t  x;
        int    tc_hits = 0;
        s.push_back(mk(0, 1, 7, 1, 1, 1));
        for (int i = 0; i < 6; i++) s.push_back(mk(0, 0, 0, 1, 1, 1));
        s.push_back(mk(0, 0, 0, 1, 0, 1));   // direction change keeps it stopped
        s.push_back(mk(0, 0, 0, 1, 1, 0));   // OneShot falls: clear and wrap 9->0
        s.push_back(mk(0, 0, 0, 1, 1, 1));
        s.push_back(mk(0, 1, 8, 1, 1, 1));
        s.push_back(mk(0, 0, 0, 1, 1, 1));
        s.push_back(mk(0, 0, 0, 1, 1, 1));
        s.push_back(mk(0, 1, 0, 1, 1, 1));   // load clears Done, counting resumes
        s.push_back(mk(0, 0, 0, 1, 1, 1));
        s.push_back(mk(0, 0, 0, 1, 1, 1));
        foreach (s[i]) begin
            apply(s[i]);
            #1; x = sb[0]; compared++;
            if (i >= 1 && i <= 6 && tc === 1'b1) tc_hits++;
            if (tc !== x.tc) begin mismatched++; $display("FAIL oneshot_tc[%0d]: got %b want %b (count=%0d)", i, tc, x.tc, count); end
            @(posedge clk); #1; x = sb.pop_front(); compared++;
            if (count !== x.cnt || done !== x.dn) begin
                mismatched++; $display("FAIL oneshot[%0d]: count=%0d done=%b want count=%0d done=%b", i, count, done, x.cnt, x.dn);
            end
        end
        compared++;
        if (tc_hits != 1) begin mismatched++; $display("FAIL oneshot_tc_pulse: %0d cycles high want 1", tc_hits); end
    endtask

    task automatic test_simultaneous();
        stim_t s[$];
        exp_t  x;
        s.push_back(mk(1, 1, 5, 1, 1, 0));
        s.push_back(mk(0, 1, 5, 1, 1, 0));
        for (int i = 0; i < 3; i++) s.push_back(mk(0, 0, 0, 0, 1, 0));
        s.push_back(mk(0, 1, 9, 0, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 0));   // at terminal but disabled: Tc low
        foreach (s[i]) begin
            apply(s[i]);
            #1; x = sb[0]; compared++;
            if (tc !== x.tc) begin mismatched++; $display("FAIL simul_tc[%0d]: got %b want %b (count=%0d)", i, tc, x.tc, count); end
            @(posedge clk); #1; x = sb.pop_front(); compared++;
            if (count !== x.cnt || done !== x.dn) begin
                mismatched++; $display("FAIL simul[%0d]: count=%0d done=%b want count=%0d done=%b", i, count, done, x.cnt, x.dn);
            end
            if (i == 1) begin
                compared++;
                if (count !== 4'd5) begin mismatched++; $display("FAIL load_over_en: count=%0d want 5", count); end
            end
        end
    endtask

    task automatic test_reset_midop();
        stim_t s[$];
        exp_t  x;
        s.push_back(mk(0, 1, 7, 1, 1, 1));
        for (int i = 0; i < 4; i++) s.push_back(mk(0, 0, 0, 1, 1, 1));
        s.push_back(mk(1, 0, 0, 1, 1, 1));
        s.push_back(mk(0, 0, 0, 1, 1, 1));
        foreach (s[i]) begin
            apply(s[i]);
            #1; x = sb[0]; compared++;
            if (tc !== x.tc) begin mismatched++; $display("FAIL midrst_tc[%0d]: got %b want %b", i, tc, x.tc); end
            @(posedge clk); #1; x = sb.pop_front(); compared++;
            if (count !== x.cnt || done !== x.dn) begin
                mismatched++; $display("FAIL midrst[%0d]: count=%0d done=%b want count=%0d done=%b", i, count, done, x.cnt, x.dn);
            end
            if (i == 4) begin
                compared++;
                if (done !== 1'b1 || count !== 4'd9) begin mismatched++; $display("FAIL midrst_done: count=%0d done=%b want 9/1", count, done); end
            end
            if (i == 5) begin
                compared++;
                if (rv4_count !== 4'd4 || rv4_done !== 1'b0) begin
                    mismatched++; $display("FAIL midrst_rv4: count=%0d done=%b want 4/0", rv4_count, rv4_done);
                end
            end
        end
    endtask

    task automatic test_mod16();
        int want_cnt[$];
        int want_tc[$];
        int w;
        // reset, load 14, up x3 (14->15->0->1), down x3 (1->0->15->14)
        logic [3:0] ld[8] = '{4'd0, 4'd14, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        logic       ue[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int         ec[8] = '{0, 14, 15, 0, 1, 0, 15, 14};
        int         et[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m_reset = (i == 0); m_load = (i == 1); m_din = ld[i];
            m_en = (i >= 2); m_up = ue[i];
            want_cnt.push_back(ec[i]);
            want_tc.push_back(et[i]);
            #1;
            if (i >= 1) begin
                w = want_tc.pop_front(); compared++;
                if (m_tc !== 1'(w)) begin mismatched++; $display("FAIL m16_tc[%0d]: got %b want %0d (count=%0d)", i, m_tc, w, m_count); end
            end else void'(want_tc.pop_front());
            @(posedge clk); #1;
            w = want_cnt.pop_front(); compared++;
            if (m_count !== 4'(w) || m_done !== 1'b0) begin
                mismatched++; $display("FAIL m16[%0d]: count=%0d done=%b want count=%0d done=0", i, m_count, m_done, w);
            end
        end
        m_en = 1'b0;
    endtask

    task automatic test_cascade();
        int w;
        int tc_hits = 0;
        @(negedge clk); c_reset = 1'b1; c_en = 1'b0;
        @(posedge clk); #1; compared++;
        if (lo_count !== 4'd0 || hi_count !== 4'd0) begin
            mismatched++; $display("FAIL casc_reset: %0d%0d want 00", hi_count, lo_count);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); c_reset = 1'b0; c_en = 1'b1;
            cq.push_back((i + 1) % 100);
            #1; compared++;
            if (hi_tc === 1'b1) tc_hits++;
            if (hi_tc !== (i == 99)) begin mismatched++; $display("FAIL casc_tc[%0d]: got %b at %0d%0d", i, hi_tc, hi_count, lo_count); end
            @(posedge clk); #1;
            w = cq.pop_front(); compared++;
            if (hi_count !== 4'(w / 10) || lo_count !== 4'(w % 10)) begin
                mismatched++; $display("FAIL casc[%0d]: got %0d%0d want %0d", i, hi_count, lo_count, w);
            end
        end
        compared++;
        if (tc_hits != 1) begin mismatched++; $display("FAIL casc_tc_count: %0d want 1", tc_hits); end
        c_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wrap_up();
        test_down_clamp();
        test_oneshot();
        test_simultaneous();
        test_reset_midop();
        test_mod16();
        test_cascade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
